uart_cmd_sequencer: RTL

Command-frame controller that sits directly behind the UART receiver. It turns the received byte stream into framed commands that load multiplier operands or reprogram the receiver baud rate. It drives `freq_control` back into the receiver and presents operand pairs to the multiplier datapath through a valid/ready handshake.

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_byte_strobe.sv | 18 +
 rtl/uart_cmd_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command-frame sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        COMMIT  = 3'd4,
        ISSUE   = 3'd5
    } seq_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_MUL   = 8'h01;
    localparam logic [7:0] CMD_BAUD  = 8'h02;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's rx_valid level into a single-cycle byte event.
module uart_byte_strobe (
    input  logic uart_clock,
    input  logic uart_reset,
    input  logic rx_valid,
    output logic byte_evt
);

    logic rx_valid_q;

    always_ff @(posedge uart_clock) begin
        if (uart_reset) rx_valid_q <= 1'b0;
        else            rx_valid_q <= rx_valid;
    end

    assign byte_evt = rx_valid & ~rx_valid_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames UART bytes into MUL/BAUD commands; optional CHK byte under UART_CMD_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// CMD     | expecting command byte
// PAYLOAD | shifting payload bytes into the buffer
// CHECK   | expecting XOR checksum (checksum builds only)
// COMMIT  | one cycle: load operands or freq_control
// ISSUE   | op_valid high until op_ready
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int          OPERAND_W      = 8,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
    input  logic                 uart_clock,
    input  logic                 uart_reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [1:0]           freq_control,
    output logic                 busy,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    input  logic                 clr_err
);

    localparam int          OPB      = OPERAND_W / 8;
    localparam int          BUF_W    = 2 * OPERAND_W;
    localparam logic [3:0]  PL_MUL   = 4'(2 * OPB);
    localparam logic [23:0] TMO_LOAD = TIMEOUT_CYCLES - 24'd1;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_CMD     = CMD;
    localparam logic [2:0] ST_PAYLOAD = PAYLOAD;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK   = CHECK;
`endif
    localparam logic [2:0] ST_COMMIT  = COMMIT;
    localparam logic [2:0] ST_ISSUE   = ISSUE;

    logic             byte_evt;
    logic [2:0]       state, state_nx;
    logic [7:0]       cmd_q;
    logic [3:0]       pl_cnt;
    logic [BUF_W-1:0] pl_buf;
    logic [23:0]      timer;
    logic             in_frame, tmo;
    logic             err_set;
    logic [1:0]       err_val;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       chk_acc;
`endif

    uart_byte_strobe u_strobe (
        .uart_clock (uart_clock),
        .uart_reset (uart_reset),
        .rx_valid   (rx_valid),
        .byte_evt   (byte_evt)
    );

`ifdef UART_CMD_CHECKSUM_EN
    assign in_frame = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CHECK);
`else
    assign in_frame = (state == ST_CMD) || (state == ST_PAYLOAD);
`endif
    // Timer is reloaded on every byte event, so it only expires after a silent gap.
    assign tmo = in_frame && !byte_evt && (timer == 24'd0);

    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        err_val  = ERR_NONE;
        if (tmo) begin
            state_nx = ST_IDLE;
            err_set  = 1'b1;
            err_val  = ERR_TIMEOUT;
        end else begin
            case (state)
                ST_IDLE:
                    if (byte_evt && rx_data == SYNC_BYTE) state_nx = ST_CMD;
                ST_CMD:
                    if (byte_evt) begin
                        if (rx_data == CMD_MUL || rx_data == CMD_BAUD) begin
                            state_nx = ST_PAYLOAD;
                        end else begin
                            state_nx = ST_IDLE;
                            err_set  = 1'b1;
                            err_val  = ERR_BAD_CMD;
                        end
                    end
                ST_PAYLOAD:
                    if (byte_evt && pl_cnt == 4'd1) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_nx = ST_CHECK;
`else
                        state_nx = ST_COMMIT;
`endif
                    end
`ifdef UART_CMD_CHECKSUM_EN
                ST_CHECK:
                    if (byte_evt) begin
                        if (rx_data == chk_acc) begin
                            state_nx = ST_COMMIT;
                        end else begin
                            state_nx = ST_IDLE;
                            err_set  = 1'b1;
                            err_val  = ERR_CHKSUM;
                        end
                    end
`endif
                ST_COMMIT:
                    state_nx = (cmd_q == CMD_MUL) ? ST_ISSUE : ST_IDLE;
                ST_ISSUE:
                    if (op_ready) state_nx = ST_IDLE;
                default:
                    state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge uart_clock) begin
        if (uart_reset) begin
            state        <= ST_IDLE;
            cmd_q        <= 8'h00;
            pl_cnt       <= 4'd0;
            pl_buf       <= '0;
            timer        <= 24'd0;
            op_a         <= '0;
            op_b         <= '0;
            op_valid     <= 1'b0;
            freq_control <= 2'b00;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= ERR_NONE;
`ifdef UART_CMD_CHECKSUM_EN
            chk_acc      <= 8'h00;
`endif
        end else begin
            state    <= state_nx;
            op_valid <= (state_nx == ST_ISSUE);
            busy     <= (state_nx != ST_IDLE);

            if (byte_evt)            timer <= TMO_LOAD;
            else if (timer != 24'd0) timer <= timer - 24'd1;

            if (state == ST_CMD && byte_evt) begin
                cmd_q  <= rx_data;
                pl_cnt <= (rx_data == CMD_MUL) ? PL_MUL : 4'd1;
`ifdef UART_CMD_CHECKSUM_EN
                chk_acc <= rx_data;
`endif
            end

            if (state == ST_PAYLOAD && byte_evt && !tmo) begin
                pl_buf <= {pl_buf[BUF_W-9:0], rx_data};
                pl_cnt <= pl_cnt - 4'd1;
`ifdef UART_CMD_CHECKSUM_EN
                chk_acc <= chk_acc ^ rx_data;
`endif
            end

            if (state == ST_COMMIT) begin
                if (cmd_q == CMD_MUL) begin
                    op_a <= pl_buf[BUF_W-1 -: OPERAND_W];
                    op_b <= pl_buf[OPERAND_W-1:0];
                end else begin
                    freq_control <= pl_buf[1:0];
                end
            end

            // A new error overrides a simultaneous clear; otherwise the first error wins.
            if (err_set) begin
                frame_err <= 1'b1;
                if (!frame_err || clr_err) err_code <= err_val;
            end else if (clr_err) begin
                frame_err <= 1'b0;
                err_code  <= ERR_NONE;
            end
        end
    end

endmodule
